// File: rtl/flp_pkg.sv
// Shared floating-point helpers: operand classes, bias/width helpers, canonical NaN.
package flp_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } flp_cls_e;

    // Widest packed format the NaN builder can produce
    localparam int unsigned FLP_MAX_W = 64;

    // Exponent bias for an EWIDTH-bit exponent field
    function automatic int unsigned flp_bias(input int unsigned ewidth);
        return (32'd1 << (ewidth - 32'd1)) - 32'd1;
    endfunction

    // Packed width {sign, exp, frac}
    function automatic int unsigned flp_width(input int unsigned ewidth, input int unsigned swidth);
        return 32'd1 + ewidth + swidth;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
    function automatic logic [FLP_MAX_W-1:0] flp_qnan(input int unsigned ewidth, input int unsigned swidth);
        logic [FLP_MAX_W-1:0] r;
        r = ((FLP_MAX_W'(1) << ewidth) - FLP_MAX_W'(1)) << swidth;
        r = r | (FLP_MAX_W'(1) << (swidth - 32'd1));
        return r;
    endfunction

    // Operand class from field predicates; denormals fall into ZERO
    function automatic flp_cls_e flp_classify(input logic exp_zero, input logic exp_ones, input logic frac_zero);
        if (exp_zero)      return CLS_ZERO;
        else if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
        else               return CLS_NORM;
    endfunction

endpackage

// File: rtl/flp_mul_if.sv
// Operand/product bus of the FP multiplier; no handshake, one pair per cycle.
interface flp_mul_if #(
    parameter int unsigned W = 32
) ();
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [W-1:0] o_p;

    modport master (output i_a, output i_b, input o_p);
    modport slave  (input i_a, input i_b, output o_p);
endinterface

// File: rtl/flp_mul_round.sv
// Stage-2 combinational normalize, round-to-nearest-even, range check and pack.
// Build option: FLP_MUL_STICKY_EN includes the discarded product bits in sticky.
module flp_mul_round
    import flp_pkg::*;
#(
    parameter int unsigned EWIDTH  = 8,
    parameter int unsigned SWIDTH  = 23,
    parameter int unsigned RSWIDTH = 2
) (
    input  flp_cls_e                    cls,
    input  logic                        sign,
    input  logic signed [EWIDTH+1:0]    exp_sum,
    input  logic [2*SWIDTH+1:0]         prod,
    output logic [EWIDTH+SWIDTH:0]      result_c
);
    localparam int unsigned W  = flp_width(EWIDTH, SWIDTH);
    localparam int unsigned PW = 2 * SWIDTH + 2;
    localparam int unsigned XW = EWIDTH + 2;
    localparam int unsigned LW = SWIDTH + 1 - RSWIDTH;
    localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EWIDTH) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

`ifdef FLP_MUL_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic [PW-2:0]          norm;
    logic [SWIDTH-1:0]      frac;
    logic [RSWIDTH-1:0]     rbits;
    logic [LW-1:0]          sbits;
    logic                   sticky;
    logic                   up;
    logic [SWIDTH:0]        mant_r;
    logic signed [XW-1:0]   exp_n;
    logic signed [XW-1:0]   exp_f;

    // Normalize below the hidden bit, round, renormalize on carry, then select result
    always_comb begin
        norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        exp_n    = exp_sum + XW'(prod[PW-1]);
        frac     = norm[PW-2 -: SWIDTH];
        rbits    = norm[PW-2-SWIDTH -: RSWIDTH];
        sbits    = norm[LW-1:0];
        sticky   = STICKY_EN & (|sbits);
        up       = rbits[RSWIDTH-1] & ((|rbits[RSWIDTH-2:0]) | sticky | frac[0]);
        mant_r   = {1'b0, frac} + (SWIDTH+1)'(up);
        exp_f    = exp_n + XW'(mant_r[SWIDTH]);
        result_c = '0;
        case (cls)
            CLS_NAN:  result_c = W'(flp_qnan(EWIDTH, SWIDTH));
            CLS_INF:  result_c = {sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
            CLS_ZERO: result_c = {sign, {(EWIDTH+SWIDTH){1'b0}}};
            default: begin
                if (exp_f >= EXP_INF)
                    result_c = {sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
                else if (exp_f <= EXP_ZERO)
                    result_c = {sign, {(EWIDTH+SWIDTH){1'b0}}};
                else
                    result_c = {sign, exp_f[EWIDTH-1:0], mant_r[SWIDTH-1:0]};
            end
        endcase
    end

endmodule

// File: rtl/flp_mul.sv
// Two-stage pipelined floating-point multiplier (RNE, flush-to-zero).
// Build option: FLP_MUL_STICKY_EN (exact sticky in rounding, see flp_mul_round).
module flp_mul
    import flp_pkg::*;
#(
    parameter int unsigned EWIDTH  = 8,
    parameter int unsigned SWIDTH  = 23,
    parameter int unsigned RSWIDTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    flp_mul_if.slave  bus
);
    localparam int unsigned W    = flp_width(EWIDTH, SWIDTH);
    localparam int unsigned PW   = 2 * SWIDTH + 2;
    localparam int unsigned XW   = EWIDTH + 2;
    localparam int unsigned BIAS = flp_bias(EWIDTH);

    logic                   sign_a, sign_b;
    logic [EWIDTH-1:0]      exp_a, exp_b;
    logic [SWIDTH-1:0]      frac_a, frac_b;
    flp_cls_e               cls_a, cls_b, cls_c;
    logic                   sign_c;
    logic signed [XW-1:0]   exp_c;
    logic [PW-1:0]          prod_c;

    flp_cls_e               s1_cls;
    logic                   s1_sign;
    logic signed [XW-1:0]   s1_exp;
    logic [PW-1:0]          s1_prod;
    logic [W-1:0]           result_c;

    assign sign_a = bus.i_a[W-1];
    assign exp_a  = bus.i_a[W-2 -: EWIDTH];
    assign frac_a = bus.i_a[SWIDTH-1:0];
    assign sign_b = bus.i_b[W-1];
    assign exp_b  = bus.i_b[W-2 -: EWIDTH];
    assign frac_b = bus.i_b[SWIDTH-1:0];

    // Classify operands, resolve special-case priority, form exponent sum and mantissa product
    always_comb begin
        cls_a  = flp_classify(exp_a == '0, exp_a == '1, frac_a == '0);
        cls_b  = flp_classify(exp_b == '0, exp_b == '1, frac_b == '0);
        cls_c  = CLS_NORM;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF))
            cls_c = CLS_NAN;
        else if (cls_a == CLS_INF || cls_b == CLS_INF)
            cls_c = CLS_INF;
        else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
            cls_c = CLS_ZERO;
        sign_c = sign_a ^ sign_b;
        exp_c  = XW'(exp_a) + XW'(exp_b) - XW'(BIAS);
        prod_c = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
    end

    // Stage 1 pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cls  <= CLS_ZERO;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_prod <= '0;
        end else begin
            s1_cls  <= cls_c;
            s1_sign <= sign_c;
            s1_exp  <= exp_c;
            s1_prod <= prod_c;
        end
    end

    flp_mul_round #(
        .EWIDTH  (EWIDTH),
        .SWIDTH  (SWIDTH),
        .RSWIDTH (RSWIDTH)
    ) u_round (
        .cls      (s1_cls),
        .sign     (s1_sign),
        .exp_sum  (s1_exp),
        .prod     (s1_prod),
        .result_c (result_c)
    );

    // Stage 2 register: packed product
    always_ff @(posedge clk) begin
        if (rst) bus.o_p <= '0;
        else     bus.o_p <= result_c;
    end

endmodule

// File: tb/tb_flp_mul.sv
// Directed bench for flp_mul in FP32 configuration.
module tb_flp_mul;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] pa [6];
    logic [31:0] pb [6];
    logic [31:0] pe [6];

    always #5 clk = ~clk;

    flp_mul_if #(.W(32)) bus ();

    flp_mul #(
        .EWIDTH  (8),
        .SWIDTH  (23),
        .RSWIDTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Apply one pair, wait two rising edges, compare
    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        bus.i_a = a;
        bus.i_b = b;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, bus.o_p, exp);
    endtask

    initial begin
        pa[0] = 32'h40000000; pb[0] = 32'h40800000; pe[0] = 32'h41000000;
        pa[1] = 32'hC0000000; pb[1] = 32'h40800000; pe[1] = 32'hC1000000;
        pa[2] = 32'h3FC00000; pb[2] = 32'h3F800003; pe[2] = 32'h3FC00004;
        pa[3] = 32'h3FC00000; pb[3] = 32'h3F800001; pe[3] = 32'h3FC00002;
        pa[4] = 32'h7F000000; pb[4] = 32'h40000000; pe[4] = 32'h7F800000;
        pa[5] = 32'h3FFFFFFE; pb[5] = 32'h3F800001; pe[5] = 32'h40000000;

        // Reset with live operands on the bus
        rst     = 1'b1;
        bus.i_a = 32'h40000000;
        bus.i_b = 32'h40800000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_op", bus.o_p, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_zero", bus.o_p, 32'h00000000);
        @(posedge clk);
        #1;
        chk("post_reset_first", bus.o_p, 32'h41000000);

        // Normal path and rounding
        run1("mul_main",     32'h405D2F1B, 32'h3FE4FDF4, 32'h40C5D95E);
        run1("mul_2x4",      32'h40000000, 32'h40800000, 32'h41000000);
        run1("mul_neg",      32'hC0000000, 32'h40800000, 32'hC1000000);
        run1("rnd_ulp",      32'h3F800001, 32'h3F800001, 32'h3F800002);
        run1("rnd_tie_odd",  32'h3FC00000, 32'h3F800001, 32'h3FC00002);
        run1("rnd_tie_even", 32'h3FC00000, 32'h3F800003, 32'h3FC00004);
        run1("rnd_carry",    32'h3FFFFFFE, 32'h3F800001, 32'h40000000);

        // Special operands
        run1("neg_zero",     32'h80000000, 32'h3F800000, 32'h80000000);
        run1("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000);
        run1("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        run1("zero_x_nan",   32'h00000000, 32'h7FC00000, 32'h7FC00000);
        run1("ninf_x_nzero", 32'hFF800000, 32'h80000000, 32'h7FC00000);
        run1("ninf_x_2",     32'hFF800000, 32'h40000000, 32'hFF800000);
        run1("inf_x_neg2",   32'h7F800000, 32'hC0000000, 32'hFF800000);

        // Range boundaries
        run1("overflow",     32'h7F000000, 32'h40000000, 32'h7F800000);
        run1("max_exp_ok",   32'h7F000000, 32'h3F800000, 32'h7F000000);
        run1("underflow",    32'h00800000, 32'h3F000000, 32'h00000000);
        run1("min_exp_ok",   32'h00800000, 32'h3F800000, 32'h00800000);
        run1("denorm_in",    32'h00000001, 32'h7F000000, 32'h00000000);

        // Back-to-back: pair k driven before edge k, result visible after edge k+1
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) begin
                bus.i_a = pa[k];
                bus.i_b = pb[k];
            end
            @(posedge clk);
            #1;
            if (k >= 1) chk($sformatf("pipe_%0d", k - 1), bus.o_p, pe[k - 1]);
        end

        // Reset with two operations in flight
        @(negedge clk);
        bus.i_a = 32'h40400000;
        bus.i_b = 32'h40400000;
        @(negedge clk);
        bus.i_a = 32'h40A00000;
        bus.i_b = 32'h40000000;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        chk("flight_rst", bus.o_p, 32'h00000000);
        @(negedge clk);
        rst     = 1'b0;
        bus.i_a = 32'h40000000;
        bus.i_b = 32'h40800000;
        @(posedge clk);
        #1;
        chk("flight_hold0", bus.o_p, 32'h00000000);
        @(posedge clk);
        #1;
        chk("flight_new", bus.o_p, 32'h41000000);
        @(posedge clk);
        #1;
        chk("const_hold", bus.o_p, 32'h41000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
